// File: rtl/ram_2rw_port_ctrl_if.sv
// rtl/ram_2rw_port_ctrl_if.sv - per-client request/response and RAM-port bundle
//
// Purpose: groups one client's request stream, its response stream and the
//   matching RAM port into a single interface. One instance per client/port.
// Signals:
//   req_v/req_w/req_addr/req_data/req_mask  client request (write = req_w)
//   req_rdy                                 request accepted when req_v & req_rdy
//   resp_v/resp_data/resp_rdy               read response, popped when resp_v & resp_rdy
//   ram_v/ram_w/ram_addr/ram_w_data/ram_w_mask  RAM port drive
//   ram_r_data                              RAM read data, valid the cycle after a read issue
// Modports:
//   master  client + RAM side (drives requests, resp_rdy and RAM read data)
//   slave   the controller
interface ram_2rw_port_ctrl_if #(
  parameter int width_p = 32,
  parameter int els_p   = 64
);
  localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int mask_width_lp = width_p / 8;

  logic                     req_v;
  logic                     req_w;
  logic [addr_width_lp-1:0] req_addr;
  logic [width_p-1:0]       req_data;
  logic [mask_width_lp-1:0] req_mask;
  logic                     req_rdy;

  logic                     resp_v;
  logic [width_p-1:0]       resp_data;
  logic                     resp_rdy;

  logic                     ram_v;
  logic                     ram_w;
  logic [addr_width_lp-1:0] ram_addr;
  logic [width_p-1:0]       ram_w_data;
  logic [mask_width_lp-1:0] ram_w_mask;
  logic [width_p-1:0]       ram_r_data;

  modport master (
    output req_v, req_w, req_addr, req_data, req_mask, resp_rdy, ram_r_data,
    input  req_rdy, resp_v, resp_data, ram_v, ram_w, ram_addr, ram_w_data, ram_w_mask
  );

  modport slave (
    input  req_v, req_w, req_addr, req_data, req_mask, resp_rdy, ram_r_data,
    output req_rdy, resp_v, resp_data, ram_v, ram_w, ram_addr, ram_w_data, ram_w_mask
  );
endinterface

// File: rtl/ram_2rw_port_ctrl.sv
// rtl/ram_2rw_port_ctrl.sv - two-client controller for a 2-port byte-masked RAM
//
// Purpose: issues client c0/c1 requests onto RAM ports 0/1, stalling the
//   same-address write/write and write/read combinations the RAM leaves
//   undefined (c0 wins write/write), and captures each port's read data into
//   a 2-entry response FIFO. Read issue is gated by a credit so the FIFO can
//   never overflow, while still sustaining one read per cycle per port.
// Ports:
//   clk_i      clock, all logic on posedge
//   reset_n_i  asynchronous active-low reset
//   c0, c1     ram_2rw_port_ctrl_if.slave, client N request/response + RAM port N
module ram_2rw_port_ctrl #(
  parameter int width_p = 32,
  parameter int els_p   = 64
) (
  input logic                 clk_i,
  input logic                 reset_n_i,
  ram_2rw_port_ctrl_if.slave  c0,
  ram_2rw_port_ctrl_if.slave  c1
);

  logic       same;
  logic       c0_wr_same;
  logic       c1_wr_same;
  logic [1:0] req_v;
  logic [1:0] req_w;
  logic [1:0] req_rdy;
  logic [1:0] resp_rdy;
  logic [1:0] resp_v;
  logic [1:0] pop;
  logic [1:0] push;
  logic [1:0] credit;
  logic [1:0] issue_rd;
  logic [width_p-1:0] r_data [2];
  logic [2:0] need [2];

  logic [1:0]         occ_q      [2];
  logic [1:0]         occ_d      [2];
  logic [1:0]         inflight_q;
  logic [1:0]         inflight_d;
  logic [1:0]         rd_ptr_q;
  logic [1:0]         rd_ptr_d;
  logic [1:0]         wr_ptr_q;
  logic [1:0]         wr_ptr_d;
  logic [width_p-1:0] fifo_q     [2][2];
  logic [width_p-1:0] fifo_d     [2][2];

  assign same       = (c0.req_addr == c1.req_addr);
  assign c0_wr_same = c0.req_v & c0.req_w & same;
  assign c1_wr_same = c1.req_v & c1.req_w & same;

  assign req_v     = {c1.req_v, c0.req_v};
  assign req_w     = {c1.req_w, c0.req_w};
  assign resp_rdy  = {c1.resp_rdy, c0.resp_rdy};
  assign r_data[0] = c0.ram_r_data;
  assign r_data[1] = c1.ram_r_data;

  assign resp_v[0] = (occ_q[0] != 2'd0);
  assign resp_v[1] = (occ_q[1] != 2'd0);
  assign pop       = resp_v & resp_rdy;
  assign push      = inflight_q;

  // Outstanding = stored + in flight - leaving this cycle; a new read may
  // issue only if a slot will still be free when its data lands.
  always_comb begin
    need = '{default: '0};
    for (int n = 0; n < 2; n++) begin
      need[n]   = {1'b0, occ_q[n]} + {2'b0, inflight_q[n]} - {2'b0, pop[n]};
      credit[n] = (need[n] < 3'd2);
    end
  end

  // Writes never need credit. c0 is never blocked by a c1 write on a write,
  // which gives c0 priority in the write/write case. Nothing is accepted
  // while reset is held so the RAM sees no enables then.
  assign req_rdy[0] = reset_n_i & (c0.req_w | (credit[0] & ~c1_wr_same));
  assign req_rdy[1] = reset_n_i & ~c0_wr_same & (c1.req_w | credit[1]);

  assign issue_rd = req_v & req_rdy & ~req_w;

  always_comb begin
    occ_d      = occ_q;
    inflight_d = issue_rd;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    fifo_d     = fifo_q;
    for (int n = 0; n < 2; n++) begin
      if (push[n]) begin
        fifo_d[n][wr_ptr_q[n]] = r_data[n];
        wr_ptr_d[n]            = ~wr_ptr_q[n];
      end
      if (pop[n]) begin
        rd_ptr_d[n] = ~rd_ptr_q[n];
      end
      occ_d[n] = occ_q[n] + {1'b0, push[n]} - {1'b0, pop[n]};
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      occ_q      <= '{default: '0};
      inflight_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Payload storage needs no reset; occupancy alone decides validity.
  always_ff @(posedge clk_i) begin
    fifo_q <= fifo_d;
  end

  assign c0.req_rdy    = req_rdy[0];
  assign c0.resp_v     = resp_v[0];
  assign c0.resp_data  = fifo_q[0][rd_ptr_q[0]];
  assign c0.ram_v      = req_v[0] & req_rdy[0];
  assign c0.ram_w      = c0.req_w;
  assign c0.ram_addr   = c0.req_addr;
  assign c0.ram_w_data = c0.req_data;
  assign c0.ram_w_mask = c0.req_mask;

  assign c1.req_rdy    = req_rdy[1];
  assign c1.resp_v     = resp_v[1];
  assign c1.resp_data  = fifo_q[1][rd_ptr_q[1]];
  assign c1.ram_v      = req_v[1] & req_rdy[1];
  assign c1.ram_w      = c1.req_w;
  assign c1.ram_addr   = c1.req_addr;
  assign c1.ram_w_data = c1.req_data;
  assign c1.ram_w_mask = c1.req_mask;

  logic [31:0] addr0_ext;
  logic [31:0] addr1_ext;
  assign addr0_ext = 32'(c0.req_addr);
  assign addr1_ext = 32'(c1.req_addr);

  a_addr0_range: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    c0.ram_v |-> (addr0_ext < 32'(els_p)));
  a_addr1_range: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    c1.ram_v |-> (addr1_ext < 32'(els_p)));
  a_no_ww_same: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(c0.ram_v & c1.ram_v & c0.ram_w & c1.ram_w & same));
  a_no_wr_same: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(c0.ram_v & c1.ram_v & (c0.ram_w ^ c1.ram_w) & same));
  a_no_push_full0: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(push[0] & (occ_q[0] == 2'd2)));
  a_no_push_full1: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(push[1] & (occ_q[1] == 2'd2)));

endmodule

// File: tb/tb_ram_2rw_port_ctrl.sv
// tb/tb_ram_2rw_port_ctrl.sv - self-checking bench for ram_2rw_port_ctrl
module tb_ram_2rw_port_ctrl;
  localparam int W = 32;
  localparam int E = 64;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ram_2rw_port_ctrl_if #(.width_p(W), .els_p(E)) c0_if ();
  ram_2rw_port_ctrl_if #(.width_p(W), .els_p(E)) c1_if ();

  ram_2rw_port_ctrl #(.width_p(W), .els_p(E)) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .c0        (c0_if),
    .c1        (c1_if)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Behavioural 2-port RAM, 1-cycle read.
  logic [31:0] ram_mem [E];
  logic [31:0] rd0, rd1;
  always @(posedge clk) begin
    if (c0_if.ram_v) begin
      if (c0_if.ram_w) ram_mem[c0_if.ram_addr] <= merge(ram_mem[c0_if.ram_addr], c0_if.ram_w_data, c0_if.ram_w_mask);
      else rd0 <= ram_mem[c0_if.ram_addr];
    end
    if (c1_if.ram_v) begin
      if (c1_if.ram_w) ram_mem[c1_if.ram_addr] <= merge(ram_mem[c1_if.ram_addr], c1_if.ram_w_data, c1_if.ram_w_mask);
      else rd1 <= ram_mem[c1_if.ram_addr];
    end
  end
  assign c0_if.ram_r_data = rd0;
  assign c1_if.ram_r_data = rd1;

  logic [31:0] shadow [E];
  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic logic f_rdy(input int p);
    return (p == 0) ? c0_if.req_rdy : c1_if.req_rdy;
  endfunction
  function automatic logic f_rv(input int p);
    return (p == 0) ? c0_if.resp_v : c1_if.resp_v;
  endfunction
  function automatic logic [31:0] f_rdata(input int p);
    return (p == 0) ? c0_if.resp_data : c1_if.resp_data;
  endfunction
  function automatic logic f_ramv(input int p);
    return (p == 0) ? c0_if.ram_v : c1_if.ram_v;
  endfunction

  // Scoreboard: reads accepted push the expected data, responses popped compare it.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (c0_if.resp_v && c0_if.resp_rdy) begin
          if (exp_q0.size() == 0) check("c0 unexpected resp", 32'd1, 32'd0);
          else begin e = exp_q0.pop_front(); check("c0 resp data", c0_if.resp_data, e); end
        end
        if (c1_if.resp_v && c1_if.resp_rdy) begin
          if (exp_q1.size() == 0) check("c1 unexpected resp", 32'd1, 32'd0);
          else begin e = exp_q1.pop_front(); check("c1 resp data", c1_if.resp_data, e); end
        end
        if (c0_if.req_v && c0_if.req_rdy && !c0_if.req_w) exp_q0.push_back(shadow[c0_if.req_addr]);
        if (c1_if.req_v && c1_if.req_rdy && !c1_if.req_w) exp_q1.push_back(shadow[c1_if.req_addr]);
        if (c0_if.req_v && c0_if.req_rdy && c0_if.req_w)
          shadow[c0_if.req_addr] = merge(shadow[c0_if.req_addr], c0_if.req_data, c0_if.req_mask);
        if (c1_if.req_v && c1_if.req_rdy && c1_if.req_w)
          shadow[c1_if.req_addr] = merge(shadow[c1_if.req_addr], c1_if.req_data, c1_if.req_mask);
      end
    end
  end

  task automatic drv(input int p, input logic v, input logic w, input logic [5:0] a,
                     input logic [31:0] d, input logic [3:0] m);
    if (p == 0) begin
      c0_if.req_v = v; c0_if.req_w = w; c0_if.req_addr = a; c0_if.req_data = d; c0_if.req_mask = m;
    end else begin
      c1_if.req_v = v; c1_if.req_w = w; c1_if.req_addr = a; c1_if.req_data = d; c1_if.req_mask = m;
    end
  endtask

  task automatic idle();
    drv(0, 1'b0, 1'b0, 6'd0, 32'd0, 4'd0);
    drv(1, 1'b0, 1'b0, 6'd0, 32'd0, 4'd0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+2 of the cycle showing resp_v.
  task automatic wait_resp(input int p, input string name, input logic [31:0] expd);
    int n;
    n = 0;
    #1;
    while (!f_rv(p) && n < 20) begin
      cyc();
      #1;
      n++;
    end
    if (n >= 20) check({name, " timeout"}, 32'd0, 32'd1);
    else check(name, f_rdata(p), expd);
  endtask

  typedef struct {
    logic       v0, w0;
    logic [5:0] a0;
    logic       v1, w1;
    logic [5:0] a1;
    logic       e0, e1;
  } vec_t;
  vec_t tbl [10];

  initial begin
    logic [31:0] d;
    for (int i = 0; i < E; i++) begin ram_mem[i] = 32'd0; shadow[i] = 32'd0; end
    rd0 = 32'd0; rd1 = 32'd0;

    tbl[0] = '{1'b1, 1'b1, 6'd3,  1'b1, 1'b1, 6'd3,  1'b1, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 6'd3,  1'b1, 1'b1, 6'd4,  1'b1, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 6'd3,  1'b1, 1'b0, 6'd3,  1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 6'd3,  1'b1, 1'b1, 6'd3,  1'b0, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 6'd3,  1'b1, 1'b0, 6'd3,  1'b1, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 6'd3,  1'b1, 1'b0, 6'd3,  1'b1, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 6'd3,  1'b0, 1'b1, 6'd3,  1'b1, 1'b1};
    tbl[7] = '{1'b1, 1'b1, 6'd10, 1'b1, 1'b0, 6'd11, 1'b1, 1'b1};
    tbl[8] = '{1'b1, 1'b0, 6'd12, 1'b1, 1'b1, 6'd13, 1'b1, 1'b1};
    tbl[9] = '{1'b0, 1'b0, 6'd14, 1'b0, 1'b0, 6'd15, 1'b1, 1'b1};

    // Reset: requests presented while held must not reach the RAM.
    c0_if.resp_rdy = 1'b1; c1_if.resp_rdy = 1'b1;
    drv(0, 1'b1, 1'b0, 6'd1, 32'd0, 4'd0);
    drv(1, 1'b1, 1'b1, 6'd2, 32'hDEAD, 4'hF);
    repeat (2) @(posedge clk);
    #2;
    check("reset ram_v0", c0_if.ram_v, 1'b0);
    check("reset ram_v1", c1_if.ram_v, 1'b0);
    check("reset resp_v0", c0_if.resp_v, 1'b0);
    check("reset resp_v1", c1_if.resp_v, 1'b0);
    idle();
    cyc();
    reset_n = 1'b1;
    #1;
    check("post reset rdy0", c0_if.req_rdy, 1'b1);
    check("post reset rdy1", c1_if.req_rdy, 1'b1);
    cyc();

    // Hazard table, FIFOs empty.
    for (int i = 0; i < 10; i++) begin
      drv(0, tbl[i].v0, tbl[i].w0, tbl[i].a0, 32'hA000_0000 + i, 4'hF);
      drv(1, tbl[i].v1, tbl[i].w1, tbl[i].a1, 32'hB000_0000 + i, 4'hF);
      #1;
      check($sformatf("vec%0d rdy0", i), f_rdy(0), tbl[i].e0);
      check($sformatf("vec%0d rdy1", i), f_rdy(1), tbl[i].e1);
      check($sformatf("vec%0d ram_v0", i), f_ramv(0), tbl[i].v0 & tbl[i].e0);
      check($sformatf("vec%0d ram_v1", i), f_ramv(1), tbl[i].v1 & tbl[i].e1);
      cyc();
      idle();
      repeat (3) cyc();
    end

    // T1: masked writes then read, latency 2.
    drv(0, 1'b1, 1'b1, 6'd5, 32'hFFFF_FFFF, 4'hF); cyc();
    drv(0, 1'b1, 1'b1, 6'd5, 32'h0000_00AA, 4'h1); cyc();
    drv(0, 1'b1, 1'b0, 6'd5, 32'd0, 4'd0);
    #1 check("t1 rd rdy", c0_if.req_rdy, 1'b1);
    cyc(); idle();
    #1 check("t1 resp_v at T+1", c0_if.resp_v, 1'b0);
    cyc();
    #1 check("t1 resp_v at T+2", c0_if.resp_v, 1'b1);
    check("t1 data", c0_if.resp_data, 32'hFFFF_FFAA);
    repeat (3) cyc();

    // T2: c0 write / c1 read same address.
    drv(0, 1'b1, 1'b1, 6'd3, 32'h1234_5678, 4'hF);
    drv(1, 1'b1, 1'b0, 6'd3, 32'd0, 4'd0);
    #1 check("t2 c1 stalled", c1_if.req_rdy, 1'b0);
    check("t2 c0 rdy", c0_if.req_rdy, 1'b1);
    cyc();
    drv(0, 1'b0, 1'b0, 6'd0, 32'd0, 4'd0);
    #1 check("t2 c1 rdy next", c1_if.req_rdy, 1'b1);
    cyc(); idle();
    wait_resp(1, "t2 data", 32'h1234_5678);
    repeat (3) cyc();

    // T3: write/write same address, c0 first, c1 lands last.
    drv(0, 1'b1, 1'b1, 6'd7, 32'h1, 4'hF);
    drv(1, 1'b1, 1'b1, 6'd7, 32'h2, 4'hF);
    #1 check("t3 c0 rdy", c0_if.req_rdy, 1'b1);
    check("t3 c1 stalled", c1_if.req_rdy, 1'b0);
    cyc();
    drv(0, 1'b0, 1'b0, 6'd0, 32'd0, 4'd0);
    #1 check("t3 c1 rdy next", c1_if.req_rdy, 1'b1);
    cyc(); idle(); cyc();
    drv(0, 1'b1, 1'b0, 6'd7, 32'd0, 4'd0);
    cyc(); idle();
    wait_resp(0, "t3 data", 32'h2);
    repeat (3) cyc();

    // T4: backpressure, credit limits to 2 outstanding.
    for (int i = 0; i < 3; i++) begin
      drv(0, 1'b1, 1'b1, 6'(20 + i), 32'hC0DE_0020 + i, 4'hF); cyc();
    end
    idle();
    c0_if.resp_rdy = 1'b0;
    drv(0, 1'b1, 1'b0, 6'd20, 32'd0, 4'd0);
    #1 check("t4 rd0 rdy", c0_if.req_rdy, 1'b1);
    cyc();
    drv(0, 1'b1, 1'b0, 6'd21, 32'd0, 4'd0);
    #1 check("t4 rd1 rdy", c0_if.req_rdy, 1'b1);
    cyc();
    drv(0, 1'b1, 1'b0, 6'd22, 32'd0, 4'd0);
    #1 check("t4 rd2 stalled", c0_if.req_rdy, 1'b0);
    cyc();
    #1 check("t4 full stalled", c0_if.req_rdy, 1'b0);
    check("t4 head", c0_if.resp_data, 32'hC0DE_0020);
    cyc();
    c0_if.resp_rdy = 1'b1;
    #1 check("t4 rdy on pop", c0_if.req_rdy, 1'b1);
    cyc(); idle();
    repeat (6) cyc();

    // T5: both read same address, then full-rate reads.
    drv(1, 1'b1, 1'b1, 6'd9, 32'h9999_0009, 4'hF); cyc();
    drv(0, 1'b1, 1'b0, 6'd9, 32'd0, 4'd0);
    drv(1, 1'b1, 1'b0, 6'd9, 32'd0, 4'd0);
    #1 check("t5 rdy0", c0_if.req_rdy, 1'b1);
    check("t5 rdy1", c1_if.req_rdy, 1'b1);
    cyc(); idle();
    wait_resp(0, "t5 c0 data", 32'h9999_0009);
    check("t5 c1 v", c1_if.resp_v, 1'b1);
    check("t5 c1 data", c1_if.resp_data, 32'h9999_0009);
    cyc();
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      drv(0, 1'b1, 1'b1, 6'(30 + i), d, 4'hF);
      drv(1, 1'b1, 1'b1, 6'(40 + i), ~d, 4'hF);
      cyc();
    end
    for (int i = 0; i < 8; i++) begin
      drv(0, 1'b1, 1'b0, 6'(30 + i), 32'd0, 4'd0);
      drv(1, 1'b1, 1'b0, 6'(40 + i), 32'd0, 4'd0);
      #1 check($sformatf("t5 rate rdy0 %0d", i), c0_if.req_rdy, 1'b1);
      check($sformatf("t5 rate rdy1 %0d", i), c1_if.req_rdy, 1'b1);
      cyc();
    end
    idle();
    repeat (6) cyc();
    check("drain q0", 32'(exp_q0.size()), 32'd0);
    check("drain q1", 32'(exp_q1.size()), 32'd0);

    // T6: reset with a read in flight and one entry queued.
    c0_if.resp_rdy = 1'b0;
    drv(0, 1'b1, 1'b0, 6'd5, 32'd0, 4'd0); cyc();
    drv(0, 1'b1, 1'b0, 6'd5, 32'd0, 4'd0); cyc();
    idle();
    #1 check("t6 pre resp_v", c0_if.resp_v, 1'b1);
    reset_n = 1'b0;
    #1 check("t6 reset resp_v", c0_if.resp_v, 1'b0);
    exp_q0.delete();
    exp_q1.delete();
    cyc(); cyc();
    reset_n = 1'b1;
    c0_if.resp_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      check($sformatf("t6 no resp0 %0d", i), c0_if.resp_v, 1'b0);
      check($sformatf("t6 no resp1 %0d", i), c1_if.resp_v, 1'b0);
    end
    check("end q0", 32'(exp_q0.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
